// File: rtl/tsu_pkg.sv
// tsu_pkg: shared speed codes, rx FSM states, framing constants and latency-compensation helper
package tsu_pkg;
  typedef enum logic [1:0] {SPD_10 = 2'b00, SPD_100 = 2'b01, SPD_1000 = 2'b10, SPD_RSVD = 2'b11} speed_e;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_e;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;
  function automatic logic [79:0] ts_sub_ns(input logic [79:0] t, input logic [31:0] lat);
    logic [47:0] s;
    logic [31:0] n;
    s = t[79:32];
    n = t[31:0];
    return (n < lat) ? {s - 48'd1, n + NS_PER_SEC - lat} : {s, n - lat};
  endfunction
endpackage

// File: rtl/tsu_ts_cdc.sv
// tsu_ts_cdc: toggle request/ack handshake that captures rtc_time in the rtc_clk domain
module tsu_ts_cdc #(
  parameter int TS_W = 80
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rtc_clk,
  input  logic [TS_W-1:0] rtc_time,
  input  logic            req,
  output logic            ts_valid,
  output logic [TS_W-1:0] ts,
  output logic            miss
);
  logic req_t, ack_t, ack_d, busy, rtc_rst;
  logic [1:0] req_s, ack_s, rtc_rst_s;
  logic [TS_W-1:0] cap;
  assign rtc_rst = rtc_rst_s[1];
  assign busy = req_t ^ ack_s[1];
  assign miss = req & busy;
  // request side: launch a toggle when idle, pulse ts_valid one cycle after the synchronised ack edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_t <= 1'b0;
      ack_s <= 2'b00;
      ack_d <= 1'b0;
      ts_valid <= 1'b0;
      ts <= '0;
    end else begin
      if (req && !busy) req_t <= ~req_t;
      ack_s <= {ack_s[0], ack_t};
      ack_d <= ack_s[1];
      ts_valid <= ack_s[1] ^ ack_d;
      if (ack_s[1] ^ ack_d) ts <= cap;
    end
  // rtc-domain reset: asserts immediately, releases on rtc_clk
  always_ff @(posedge rtc_clk or posedge rst)
    if (rst) rtc_rst_s <= 2'b11;
    else rtc_rst_s <= {rtc_rst_s[0], 1'b0};
  // rtc side: on a synchronised request edge freeze rtc_time and toggle the ack
  always_ff @(posedge rtc_clk or posedge rtc_rst)
    if (rtc_rst) begin
      req_s <= 2'b00;
      ack_t <= 1'b0;
      cap <= '0;
    end else begin
      req_s <= {req_s[0], req_t};
      if (req_s[1] ^ ack_t) begin
        cap <= rtc_time;
        ack_t <= req_s[1];
      end
    end
endmodule

// File: rtl/rgmii_tsu_rx.sv
// rgmii_tsu_rx: RGMII receive framer with SFD timestamping; define TSU_LAT_COMP_EN to subtract LAT_NS from timestamps
module rgmii_tsu_rx
  import tsu_pkg::*;
#(
  parameter int TS_W   = 80,
  parameter int LAT_NS = 0,
  parameter int MISS_W = 16
) (
  input  logic              rgmii_clk,
  input  logic              rst,
  input  logic              rtc_clk,
  input  logic [TS_W-1:0]   rtc_time,
  input  logic [1:0]        speed,
  input  logic [3:0]        rxd_r,
  input  logic [3:0]        rxd_f,
  input  logic              rxctl_r,
  input  logic              rxctl_f,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_err,
  output logic              ts_valid,
  output logic [TS_W-1:0]   ts_out,
  output logic [MISS_W-1:0] ts_miss_cnt
);
  if (TS_W != 80 || LAT_NS < 0 || LAT_NS > 999_999_999) begin : g_cfg_err
    $error("rgmii_tsu_rx: unsupported TS_W or LAT_NS");
  end
  speed_e spd;
  rx_state_e state;
  logic gig, ph, a_dv, a_er, a_vld, h_vld, h_sop, sop_pend, err, sfd, miss, c_valid;
  logic [3:0] lo;
  logic [7:0] a_data, h_data;
  logic [TS_W-1:0] c_ts;
  assign gig = spd == SPD_1000;
  assign sfd = state == PREAMBLE && a_dv && a_vld && a_data == SFD_BYTE;
  // line rate is only sampled between frames so mid-frame changes are ignored
  always_ff @(posedge rgmii_clk or posedge rst)
    if (rst) spd <= SPD_10;
    else if (!rxctl_r) spd <= speed_e'(speed);
  // byte assembly: whole byte per cycle at 1000M, low nibble then high nibble otherwise
  always_ff @(posedge rgmii_clk or posedge rst)
    if (rst) begin
      ph <= 1'b0;
      lo <= 4'h0;
      a_dv <= 1'b0;
      a_er <= 1'b0;
      a_vld <= 1'b0;
      a_data <= 8'h00;
    end else begin
      a_dv <= rxctl_r;
      a_er <= rxctl_r ^ rxctl_f;
      ph <= rxctl_r && !gig && !ph;
      lo <= rxd_r;
      a_vld <= rxctl_r && (gig || ph);
      a_data <= gig ? {rxd_f, rxd_r} : {rxd_r, lo};
    end
  // framing FSM; each DATA byte waits one slot so the final one can carry eop
  always_ff @(posedge rgmii_clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      h_vld <= 1'b0;
      h_sop <= 1'b0;
      h_data <= 8'h00;
      sop_pend <= 1'b0;
      err <= 1'b0;
      out_valid <= 1'b0;
      out_data <= 8'h00;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_err <= 1'b0;
    end else begin
      out_valid <= h_vld && (!a_dv || a_vld);
      out_data <= h_data;
      out_sop <= h_sop;
      out_eop <= !a_dv;
      out_err <= !a_dv && err;
      sop_pend <= sfd || (sop_pend && !(state == DATA && a_vld));
      err <= sfd ? 1'b0 : err || (state == DATA && a_dv && a_er);
      if (!a_dv) begin
        state <= IDLE;
        h_vld <= 1'b0;
      end else if (a_vld) begin
        case (state)
          IDLE: state <= a_data == PREAMBLE_BYTE ? PREAMBLE : DROP;
          PREAMBLE: state <= a_data == SFD_BYTE ? DATA : a_data == PREAMBLE_BYTE ? PREAMBLE : DROP;
          DATA: begin
            h_vld <= 1'b1;
            h_data <= a_data;
            h_sop <= sop_pend;
          end
          default: ;
        endcase
      end
    end
  // count SFDs that arrived while a timestamp transfer was still in flight
  always_ff @(posedge rgmii_clk or posedge rst)
    if (rst) ts_miss_cnt <= '0;
    else if (miss && !(&ts_miss_cnt)) ts_miss_cnt <= ts_miss_cnt + 1'b1;
  tsu_ts_cdc #(.TS_W(TS_W)) u_cdc (
    .clk(rgmii_clk),
    .rst(rst),
    .rtc_clk(rtc_clk),
    .rtc_time(rtc_time),
    .req(sfd),
    .ts_valid(c_valid),
    .ts(c_ts),
    .miss(miss)
  );
`ifdef TSU_LAT_COMP_EN
  // extra stage removes the fixed PHY/pipeline latency from the captured time
  always_ff @(posedge rgmii_clk or posedge rst)
    if (rst) begin
      ts_valid <= 1'b0;
      ts_out <= '0;
    end else begin
      ts_valid <= c_valid;
      ts_out <= ts_sub_ns(c_ts, 32'(LAT_NS));
    end
`else
  assign ts_valid = c_valid;
  assign ts_out = c_ts;
`endif
endmodule

// File: tb/tb_rgmii_tsu_rx.sv
// tb_rgmii_tsu_rx: randomized frames checked against a queue-based framing and timestamp model
module tb_rgmii_tsu_rx;
  typedef struct {logic [7:0] d; logic sop; logic eop; logic err;} byte_t;
  logic rgmii_clk = 0, rtc_clk = 0, rst = 1;
  logic [79:0] rtc_time = {48'd5, 32'd100};
  logic [1:0] speed = 2'd2;
  logic [3:0] rxd_r = 0, rxd_f = 0;
  logic rxctl_r = 0, rxctl_f = 0;
  logic out_valid, out_sop, out_eop, out_err, ts_valid;
  logic [7:0] out_data;
  logic [79:0] ts_out;
  logic [15:0] ts_miss_cnt;
  int checks = 0, failures = 0;
  int rtc_half = 5, cyc = 0, sop_cyc = -1, b0_cyc = 0, ts_seen = 0;
  logic [15:0] miss_exp = 0;
  byte_t exq[$];
  logic [79:0] tsq[$];

  rgmii_tsu_rx #(.TS_W(80), .LAT_NS(500), .MISS_W(16)) dut (
    .rgmii_clk(rgmii_clk), .rst(rst), .rtc_clk(rtc_clk), .rtc_time(rtc_time), .speed(speed),
    .rxd_r(rxd_r), .rxd_f(rxd_f), .rxctl_r(rxctl_r), .rxctl_f(rxctl_f),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
    .ts_valid(ts_valid), .ts_out(ts_out), .ts_miss_cnt(ts_miss_cnt)
  );

  always #4 rgmii_clk = ~rgmii_clk;
  always #(rtc_half) rtc_clk = ~rtc_clk;
  always @(posedge rtc_clk) rtc_time <= rtc_time + 80'd1;
  always @(posedge rgmii_clk) cyc++;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // total-nanoseconds arithmetic, independent of any borrow logic
  function automatic logic [79:0] comp(input logic [79:0] t, input longint lat);
    longint tot;
    tot = longint'(t[79:32]) * 64'd1000000000 + longint'(t[31:0]) - lat;
    return {48'(tot / 1000000000), 32'(tot % 1000000000)};
  endfunction

  function automatic logic [79:0] model_ts(input logic [79:0] t);
`ifdef TSU_LAT_COMP_EN
    return comp(t, 500);
`else
    return t;
`endif
  endfunction

  // compare process: every emitted byte and timestamp is checked against the model queues
  always @(negedge rgmii_clk) begin : cmp
    byte_t e;
    logic [79:0] s;
    bit hit;
    if (!rst) begin
      if (out_valid) begin
        if (exq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h required=none", out_data);
        end else begin
          e = exq.pop_front();
          check("out_data", out_data, e.d);
          check("out_sop", out_sop, e.sop);
          check("out_eop", out_eop, e.eop);
          check("out_err", out_err, e.err);
          if (out_sop) sop_cyc = cyc;
        end
      end
      if (ts_valid) begin
        ts_seen++;
        checks++;
        if (tsq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ts actual=%0h required=none", ts_out);
        end else begin
          s = tsq.pop_front();
          hit = 0;
          for (int k = 0; k <= 6; k++) if (ts_out == model_ts(s + 80'(k))) hit = 1;
          if (!hit) begin
            failures++;
            $display("FAIL ts_out actual=%0h required=%0h..+6", ts_out, model_ts(s));
          end
        end
      end
    end
  end

  task automatic cyc1(input logic [3:0] r, input logic [3:0] f, input logic cr, input logic cf);
    rxd_r = r;
    rxd_f = f;
    rxctl_r = cr;
    rxctl_f = cf;
    @(posedge rgmii_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int sp, input logic er);
    if (sp == 2) cyc1(b[3:0], b[7:4], 1'b1, !er);
    else begin
      cyc1(b[3:0], 4'h0, 1'b1, 1'b1);
      cyc1(b[7:4], 4'h0, 1'b1, 1'b1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc1(4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int sp, input int npre, input logic [7:0] sfd_b, input logic [7:0] pay[$],
                            input int err_at, input bit mid, input bit exp_ts, input int ifg);
    bit good;
    byte_t e;
    good = npre > 0 && sfd_b == 8'hD5;
    speed = 2'(sp);
    idle(1);
    for (int i = 0; i < npre; i++) send_byte(8'h55, sp, 1'b0);
    send_byte(sfd_b, sp, 1'b0);
    if (good && exp_ts) tsq.push_back(rtc_time);
    for (int i = 0; i < pay.size(); i++) begin
      if (mid && i == pay.size() / 2) speed = 2'($urandom);
      send_byte(pay[i], sp, i == err_at);
      if (i == 0) b0_cyc = cyc;
      if (good) begin
        e.d = pay[i];
        e.sop = i == 0;
        e.eop = i == pay.size() - 1;
        e.err = e.eop && err_at >= 0;
        exq.push_back(e);
      end
    end
    idle(ifg);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exq.size() != 0 || tsq.size() != 0) && n < 400) begin
      @(posedge rgmii_clk);
      n++;
    end
    repeat (4) @(posedge rgmii_clk);
    #1;
    check({name, "_drained"}, 80'(exq.size() + tsq.size()), 80'd0);
  endtask

  initial begin
    logic [7:0] p[$];
    logic [7:0] none[$];
    int t0, good_n, n, sp, npre, ea;
    check("pin_comp_borrow", comp({48'd5, 32'd200}, 500), {48'd4, 32'd999_999_700});
    check("pin_comp_plain", comp({48'd7, 32'd900}, 500), {48'd7, 32'd400});
    check("pkg_ts_sub_ns", tsu_pkg::ts_sub_ns({48'd5, 32'd200}, 32'd500), {48'd4, 32'd999_999_700});
    repeat (3) @(posedge rgmii_clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_eop", out_eop, 0);
    check("rst_ts_valid", ts_valid, 0);
    check("rst_ts_out", ts_out, 0);
    check("rst_miss", ts_miss_cnt, 0);
    rst = 0;
    idle(4);
    for (int i = 0; i < 64; i++) p.push_back(8'(i));
    t0 = ts_seen;
    send_frame(2, 7, 8'hD5, p, -1, 0, 1, 12);
    drain("gig64");
    check("gig64_ts_count", 80'(ts_seen - t0), 1);
    check("gig64_latency", 80'(sop_cyc - b0_cyc), 2);
    t0 = ts_seen;
    send_frame(1, 7, 8'hD5, p, -1, 0, 1, 12);
    drain("m100_64");
    check("m100_ts_count", 80'(ts_seen - t0), 1);
    p.delete();
    for (int i = 0; i < 10; i++) p.push_back(8'($urandom));
    send_frame(2, 7, 8'hD5, p, 4, 0, 1, 12);
    drain("gig_err");
    t0 = ts_seen;
    send_frame(2, 2, 8'h5D, none, -1, 0, 1, 12);
    drain("drop_pre");
    check("drop_ts_count", 80'(ts_seen - t0), 0);
    t0 = ts_seen;
    good_n = 0;
    for (int f = 0; f < 30; f++) begin
      sp = $urandom_range(0, 3);
      npre = $urandom_range(0, 7);
      n = $urandom_range(1, 24);
      p.delete();
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      ea = (sp == 2 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      if (npre > 0 && $urandom_range(0, 7) != 0) begin
        good_n++;
        send_frame(sp, npre, 8'hD5, p, ea, $urandom_range(0, 1) == 1, 1, 8);
      end else send_frame(sp, npre, npre > 0 ? 8'h5D : 8'hD5, p, ea, 0, 1, 8);
      drain("rand");
    end
    check("rand_ts_count", 80'(ts_seen - t0), 80'(good_n));
    check("rand_miss", ts_miss_cnt, miss_exp);
    rtc_half = 32;
    idle(20);
    t0 = ts_seen;
    p.delete();
    p.push_back(8'hA1);
    send_frame(2, 7, 8'hD5, p, -1, 0, 1, 1);
    p[0] = 8'hB2;
    send_frame(2, 7, 8'hD5, p, -1, 0, 0, 1);
    miss_exp++;
    drain("miss");
    check("miss_ts_count", 80'(ts_seen - t0), 1);
    check("miss_cnt", ts_miss_cnt, miss_exp);
    rtc_half = 5;
    idle(20);
    speed = 2'd2;
    idle(1);
    for (int i = 0; i < 7; i++) send_byte(8'h55, 2, 1'b0);
    send_byte(8'hD5, 2, 1'b0);
    send_byte(8'h11, 2, 1'b0);
    rst = 1;
    miss_exp = 0;
    idle(3);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_miss", ts_miss_cnt, miss_exp);
    rst = 0;
    idle(60);
    p.delete();
    for (int i = 0; i < 5; i++) p.push_back(8'(8'h30 + i));
    t0 = ts_seen;
    send_frame(2, 7, 8'hD5, p, -1, 0, 1, 12);
    drain("post_rst");
    check("post_rst_ts_count", 80'(ts_seen - t0), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
